// File: rtl/delay_scan_ctrl.sv
// Focal-point scan sequencer: walks every element of every focal point, asks the
// delay calculator for each delay and streams the results out with a handshake.
module delay_scan_ctrl #(
  parameter int          NUM_ELEM   = 8,
  parameter logic [15:0] ELEM_X0    = 16'd0,
  parameter logic [15:0] ELEM_PITCH = 16'd4,
  parameter int          TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_start,
  input  logic [15:0] x_focus,
  input  logic [15:0] z_first,
  input  logic [15:0] z_step,
  input  logic [7:0]  num_pts,
  output logic        calc_start,
  output logic [15:0] calc_x_i,
  output logic [15:0] calc_z_i,
  output logic [15:0] calc_x_f,
  output logic [15:0] calc_z_f,
  input  logic        calc_done,
  input  logic [7:0]  calc_delay,
  output logic        dly_valid,
  input  logic        dly_ready,
  output logic [7:0]  dly_data,
  output logic [3:0]  dly_elem,
  output logic [7:0]  dly_pt,
  output logic        dly_last,
  output logic        busy,
  output logic        scan_done,
  output logic        timeout_err
);

  localparam int          TW     = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  LAST_E = 4'(NUM_ELEM - 1);
  localparam logic [TW-1:0] LAST_T = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_CALC, OUTPUT, ADVANCE, FINISH} state_t;

  state_t        state;
  logic [3:0]    e;
  logic [7:0]    p;
  logic [7:0]    num_pts_l;
  logic [15:0]   z_step_l;
  logic [TW-1:0] tcount;

  // Elements sit on the z=0 line, so the element z coordinate is a constant.
  assign calc_z_i = 16'd0;

  // Coordinates are kept as running sums so no multiplier is needed per point.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      e           <= '0;
      p           <= '0;
      num_pts_l   <= '0;
      z_step_l    <= '0;
      tcount      <= '0;
      calc_start  <= 1'b0;
      calc_x_i    <= '0;
      calc_x_f    <= '0;
      calc_z_f    <= '0;
      dly_valid   <= 1'b0;
      dly_data    <= '0;
      dly_elem    <= '0;
      dly_pt      <= '0;
      dly_last    <= 1'b0;
      busy        <= 1'b0;
      scan_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      calc_start <= 1'b0;
      scan_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (scan_start) begin
            timeout_err <= 1'b0;
            if (num_pts == 8'd0) begin
              scan_done <= 1'b1;
              state     <= FINISH;
            end else begin
              e         <= '0;
              p         <= '0;
              num_pts_l <= num_pts;
              z_step_l  <= z_step;
              calc_x_i  <= ELEM_X0;
              calc_x_f  <= x_focus;
              calc_z_f  <= z_first;
              busy      <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          calc_start <= 1'b1;
          tcount     <= '0;
          state      <= WAIT_CALC;
        end
        WAIT_CALC: begin
          if (calc_done) begin
            dly_data  <= calc_delay;
            dly_elem  <= e;
            dly_pt    <= p;
            dly_last  <= (e == LAST_E) && (p == num_pts_l - 8'd1);
            dly_valid <= 1'b1;
            state     <= OUTPUT;
          end else if (tcount == LAST_T) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            scan_done   <= 1'b1;
            state       <= FINISH;
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        OUTPUT: begin
          if (dly_ready) begin
            dly_valid <= 1'b0;
            dly_last  <= 1'b0;
            state     <= ADVANCE;
          end
        end
        ADVANCE: begin
          if (e != LAST_E) begin
            e        <= e + 4'd1;
            calc_x_i <= calc_x_i + ELEM_PITCH;
            state    <= ISSUE;
          end else if (p != num_pts_l - 8'd1) begin
            e        <= '0;
            p        <= p + 8'd1;
            calc_x_i <= ELEM_X0;
            calc_z_f <= calc_z_f + z_step_l;
            state    <= ISSUE;
          end else begin
            busy      <= 1'b0;
            scan_done <= 1'b1;
            state     <= FINISH;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_scan_ctrl.sv
// Bench for delay_scan_ctrl: an event-timed reference model with a mock calculator
// and randomized backpressure, plus literal expectations for the directed scans.
module tb_delay_scan_ctrl;

  localparam int          NE    = 4;
  localparam logic [15:0] X0    = 16'd0;
  localparam logic [15:0] PITCH = 16'd4;
  localparam int          TMO   = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_start;
  logic [15:0] x_focus, z_first, z_step;
  logic [7:0]  num_pts;
  logic        calc_start;
  logic [15:0] calc_x_i, calc_z_i, calc_x_f, calc_z_f;
  logic        calc_done  = 1'b0;
  logic [7:0]  calc_delay = 8'd0;
  logic        dly_valid;
  logic        dly_ready  = 1'b0;
  logic [7:0]  dly_data;
  logic [3:0]  dly_elem;
  logic [7:0]  dly_pt;
  logic        dly_last, busy, scan_done, timeout_err;

  delay_scan_ctrl #(.NUM_ELEM(NE), .ELEM_X0(X0), .ELEM_PITCH(PITCH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .scan_start(scan_start), .x_focus(x_focus),
    .z_first(z_first), .z_step(z_step), .num_pts(num_pts), .calc_start(calc_start),
    .calc_x_i(calc_x_i), .calc_z_i(calc_z_i), .calc_x_f(calc_x_f), .calc_z_f(calc_z_f),
    .calc_done(calc_done), .calc_delay(calc_delay), .dly_valid(dly_valid),
    .dly_ready(dly_ready), .dly_data(dly_data), .dly_elem(dly_elem), .dly_pt(dly_pt),
    .dly_last(dly_last), .busy(busy), .scan_done(scan_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Stimulus knobs: mock 0=random latency, 1=latency 5 with delay 10*e+p, 2=never answers.
  // Ready 0=random, 1=always, 2=hold off the second output for 7 cycles.
  int mock_mode  = 1;
  int ready_mode = 1;
  bit spur_en    = 1'b0;

  typedef struct {
    logic [15:0] x_i;
    logic [15:0] z_f;
    logic [3:0]  e;
    logic [7:0]  p;
    logic        last;
  } req_t;

  req_t req_q[$];
  req_t cur;

  int t_calc = -1, t_drive = -1, t_valid = -1, t_out_clr = -1;
  int t_finish = -1, t_busy_on = -1, t_terr_set = -1, t_terr_clr = -1;
  bit armed = 1'b0, rst_pend = 1'b0, out_m = 1'b0, busy_m = 1'b0, terr_m = 1'b0;
  logic [63:0] coords_m = '0;
  logic [15:0] xf_m = '0;
  logic [7:0]  data_m = '0, pt_m = '0;
  logic [3:0]  elem_m = '0;
  logic        last_m = 1'b0;
  int out_idx = 0, vcyc = 0, hold_len = 0;

  int cs_count = 0, done_count = 0, valid_count = 0, last_count = 0, last_pos = 0;
  logic [15:0] seen_x[$];
  logic [15:0] seen_z[$];
  logic [7:0]  seen_data[$];

  logic [7:0] exp_basic [8] = '{8'd0, 8'd10, 8'd20, 8'd30, 8'd1, 8'd11, 8'd21, 8'd31};

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] xf, input logic [15:0] zf,
                               input logic [15:0] zs, input logic [7:0] np);
    @(posedge clk); #2;
    x_focus    = xf;
    z_first    = zf;
    z_step     = zs;
    num_pts    = np;
    scan_start = 1'b1;
    @(posedge clk); #2;
    scan_start = 1'b0;
  endtask

  task automatic clearRecords();
    cs_count = 0; done_count = 0; valid_count = 0; last_count = 0; last_pos = 0;
    hold_len = 0;
    seen_x.delete(); seen_z.delete(); seen_data.delete();
  endtask

  task automatic waitScanDone(input int budget);
    int start;
    int k;
    start = done_count;
    k = 0;
    while (done_count == start && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (done_count == start) begin
      checks++;
      errors++;
      $display("[TB] FAIL scan_done_wait: no scan_done within %0d cycles, required one pulse", budget);
    end
  endtask

  // Model and compare process: applies scheduled events for this cycle, checks the
  // DUT, then drives the mock calculator and ready and schedules the consequences.
  always @(negedge clk) begin : model_proc
    int   n;
    int   lat;
    logic rdy;
    logic exp_cs, exp_done;
    n = cyc;
    if (rst_pend) begin
      t_calc = -1; t_drive = -1; t_valid = -1; t_out_clr = -1;
      t_finish = -1; t_busy_on = -1; t_terr_set = -1; t_terr_clr = -1;
      out_m = 1'b0; busy_m = 1'b0; terr_m = 1'b0; coords_m = '0; xf_m = '0;
      req_q.delete();
      rst_pend = 1'b0;
      armed = 1'b1;
    end
    if (n == t_valid) begin out_m = 1'b1; vcyc = 0; end
    if (n == t_out_clr) out_m = 1'b0;
    if (n == t_terr_clr) terr_m = 1'b0;
    if (n == t_terr_set) terr_m = 1'b1;
    if (n == t_busy_on) busy_m = 1'b1;
    if (n == t_finish) busy_m = 1'b0;
    if (n == t_calc - 1) coords_m = {cur.x_i, 16'd0, xf_m, cur.z_f};
    exp_cs   = (n == t_calc);
    exp_done = (n == t_finish);

    if (armed) begin
      checkOutput("ctrl{calc_start,busy,scan_done,timeout_err,dly_valid}",
                  64'({calc_start, busy, scan_done, timeout_err, dly_valid}),
                  64'({exp_cs, busy_m, exp_done, terr_m, out_m}));
      checkOutput("coords{x_i,z_i,x_f,z_f}", {calc_x_i, calc_z_i, calc_x_f, calc_z_f}, coords_m);
      if (out_m)
        checkOutput("dly{data,elem,pt,last}", 64'({dly_data, dly_elem, dly_pt, dly_last}),
                    64'({data_m, elem_m, pt_m, last_m}));
    end

    calc_done  = 1'b0;
    calc_delay = 8'($urandom);
    case (ready_mode)
      1:       rdy = 1'b1;
      2:       rdy = out_m && (out_idx != 1 || vcyc >= 7);
      default: rdy = ($urandom_range(0, 2) != 0);
    endcase

    if (reset) begin
      rst_pend = 1'b1;
    end else begin
      if (scan_start && !busy_m && n != t_finish) begin
        t_terr_clr = n + 1;
        if (num_pts == 8'd0) begin
          t_finish = n + 1;
        end else begin
          req_q.delete();
          for (int pp = 0; pp < int'(num_pts); pp++) begin
            for (int ee = 0; ee < NE; ee++) begin
              req_t r;
              r.x_i  = 16'(int'(X0) + ee * int'(PITCH));
              r.z_f  = 16'(int'(z_first) + pp * int'(z_step));
              r.e    = 4'(ee);
              r.p    = 8'(pp);
              r.last = (pp == int'(num_pts) - 1) && (ee == NE - 1);
              req_q.push_back(r);
            end
          end
          cur       = req_q.pop_front();
          xf_m      = x_focus;
          t_busy_on = n + 1;
          t_calc    = n + 2;
          out_idx   = 0;
        end
      end
      if (n == t_calc) begin
        if (mock_mode == 2) begin
          t_finish   = n + TMO;
          t_terr_set = n + TMO;
        end else begin
          lat     = (mock_mode == 1) ? 5 : $urandom_range(1, 12);
          t_drive = n + lat;
          t_valid = n + lat + 1;
        end
      end
      if (n == t_drive) begin
        calc_done  = 1'b1;
        calc_delay = (mock_mode == 1) ? 8'(10 * int'(cur.e) + int'(cur.p)) : 8'($urandom);
        data_m = calc_delay;
        elem_m = cur.e;
        pt_m   = cur.p;
        last_m = cur.last;
      end else if (spur_en && out_m && $urandom_range(0, 3) == 0) begin
        calc_done = 1'b1;
      end
      if (out_m && rdy) begin
        if (out_idx == 1) hold_len = vcyc + 1;
        t_out_clr = n + 1;
        if (cur.last) begin
          t_finish = n + 2;
        end else begin
          cur    = req_q.pop_front();
          t_calc = n + 3;
        end
        out_idx++;
      end
      if (out_m) vcyc++;
    end
    dly_ready = rdy;

    if (armed) begin
      if (calc_start) begin
        cs_count++;
        seen_x.push_back(calc_x_i);
        seen_z.push_back(calc_z_f);
      end
      if (scan_done) done_count++;
      if (dly_valid) valid_count++;
      if (dly_valid && rdy && !reset) begin
        seen_data.push_back(dly_data);
        if (dly_last) begin
          last_count++;
          last_pos = seen_data.size();
        end
      end
    end
  end

  initial begin
    int np;
    reset = 1'b1; scan_start = 1'b0;
    x_focus = '0; z_first = '0; z_step = '0; num_pts = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    checkOutput("reset_ctrl_data", 64'({calc_start, busy, scan_done, timeout_err, dly_valid,
                dly_data, dly_elem, dly_pt, dly_last}), 64'd0);
    checkOutput("reset_coords", {calc_x_i, calc_z_i, calc_x_f, calc_z_f}, 64'd0);

    // Basic two-point scan with a fixed-latency calculator.
    clearRecords();
    applyStimulus(16'd6, 16'd8, 16'd2, 8'd2);
    waitScanDone(400);
    checkOutput("basic_out_count", 64'(seen_data.size()), 64'd8);
    for (int i = 0; i < 8 && i < seen_data.size(); i++)
      checkOutput("basic_dly_data", 64'(seen_data[i]), 64'(exp_basic[i]));
    for (int i = 0; i < 8 && i < seen_x.size(); i++)
      checkOutput("basic_calc_x_i", 64'(seen_x[i]), 64'((i % 4) * 4));
    if (seen_z.size() >= 5) begin
      checkOutput("basic_z_f_pt0", 64'(seen_z[0]), 64'd8);
      checkOutput("basic_z_f_pt1", 64'(seen_z[4]), 64'd10);
    end
    checkOutput("basic_last_count", 64'(last_count), 64'd1);
    checkOutput("basic_last_pos", 64'(last_pos), 64'd8);
    checkOutput("basic_done_count", 64'(done_count), 64'd1);

    // Backpressure on the second output.
    ready_mode = 2;
    clearRecords();
    applyStimulus(16'd6, 16'd8, 16'd2, 8'd1);
    waitScanDone(400);
    checkOutput("bp_hold_cycles", 64'(hold_len), 64'd8);
    checkOutput("bp_done_count", 64'(done_count), 64'd1);

    // Calculator never answers.
    mock_mode = 2;
    ready_mode = 0;
    clearRecords();
    applyStimulus(16'd100, 16'd50, 16'd5, 8'd3);
    waitScanDone(300);
    checkOutput("tmo_err_set", 64'(timeout_err), 64'd1);
    checkOutput("tmo_valid_count", 64'(valid_count), 64'd0);
    checkOutput("tmo_calc_count", 64'(cs_count), 64'd1);
    checkOutput("tmo_done_count", 64'(done_count), 64'd1);
    mock_mode = 0;
    applyStimulus(16'd3, 16'd4, 16'd5, 8'd1);
    checkOutput("tmo_err_cleared", 64'(timeout_err), 64'd0);
    waitScanDone(400);

    // Zero-length scan.
    clearRecords();
    applyStimulus(16'd1, 16'd1, 16'd1, 8'd0);
    waitScanDone(5);
    checkOutput("zero_calc_count", 64'(cs_count), 64'd0);
    checkOutput("zero_done_count", 64'(done_count), 64'd1);

    // scan_start while busy must not restart or lengthen the scan.
    mock_mode = 1;
    clearRecords();
    applyStimulus(16'd1, 16'd2, 16'd3, 8'd2);
    repeat (10) @(posedge clk);
    applyStimulus(16'd9, 16'd9, 16'd9, 8'd5);
    waitScanDone(600);
    checkOutput("busy_reject_calc_count", 64'(cs_count), 64'd8);
    checkOutput("busy_reject_done_count", 64'(done_count), 64'd1);

    // Focal z wraps modulo 2^16.
    clearRecords();
    applyStimulus(16'd0, 16'hFFFE, 16'd3, 8'd2);
    waitScanDone(400);
    checkOutput("wrap_pts", 64'(seen_z.size()), 64'd8);
    if (seen_z.size() >= 5) checkOutput("wrap_z_f_pt1", 64'(seen_z[4]), 64'h0001);

    // Reset while waiting on the calculator.
    clearRecords();
    applyStimulus(16'd7, 16'd9, 16'd1, 8'd2);
    for (int k = 0; k < 20 && cs_count == 0; k++) @(posedge clk);
    checkOutput("rst_saw_calc_start", 64'(cs_count), 64'd1);
    #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    checkOutput("rst_mid_ctrl_data", 64'({calc_start, busy, scan_done, timeout_err, dly_valid,
                dly_data, dly_elem, dly_pt, dly_last}), 64'd0);
    checkOutput("rst_mid_coords", {calc_x_i, calc_z_i, calc_x_f, calc_z_f}, 64'd0);
    repeat (30) @(posedge clk);
    checkOutput("rst_mid_no_done", 64'(done_count), 64'd0);
    applyStimulus(16'd7, 16'd9, 16'd1, 8'd1);
    waitScanDone(400);
    checkOutput("rst_fresh_done", 64'(done_count), 64'd1);

    // Randomized scans with random latency, ready and stray calc_done pulses.
    mock_mode = 0;
    ready_mode = 0;
    spur_en = 1'b1;
    repeat (12) begin
      clearRecords();
      np = $urandom_range(1, 4);
      applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 8'(np));
      waitScanDone(2000);
      checkOutput("rand_calc_count", 64'(cs_count), 64'(NE * np));
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_scan_ctrl.md
DELAY_SCAN_CTRL -- requirements
Module: delay_scan_ctrl

Interface
REQ-001 Parameter NUM_ELEM, default 8: transducer elements per focal point, range 2..16.
REQ-002 Parameter ELEM_X0, default 16'd0: x coordinate of element 0.
REQ-003 Parameter ELEM_PITCH, default 16'd4: x spacing between adjacent elements.
REQ-004 Parameter TIMEOUT, default 64: max cycles to wait for calc_done.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 scan_start  in  1  begin scan; sampled only in IDLE.
REQ-008 x_focus  in  16  focal x; latched at scan start.
REQ-009 z_first  in  16  first focal z; latched at scan start.
REQ-010 z_step  in  16  focal z increment per point; latched at scan start.
REQ-011 num_pts  in  8  focal points per scan; latched at scan start.
REQ-012 calc_start  out  1  one-cycle request to the delay calculator.
REQ-013 calc_x_i, calc_z_i, calc_x_f, calc_z_f  out  16 each  element and focal coordinates.
REQ-014 calc_done  in  1  calculator result-ready pulse.
REQ-015 calc_delay  in  8  calculator result; valid while calc_done is high.
REQ-016 dly_valid / dly_ready  out / in  1 / 1  output stream handshake.
REQ-017 dly_data  out  8;  dly_elem  out  4;  dly_pt  out  8;  dly_last  out  1  (last element of last point).
REQ-018 busy  out  1;  scan_done  out  1 (pulse);  timeout_err  out  1 (sticky).

Function
REQ-019 The block SHALL use states IDLE, ISSUE, WAIT_CALC, OUTPUT, ADVANCE, FINISH.
REQ-020 IDLE -> ISSUE when scan_start=1 and num_pts!=0; the inputs SHALL be latched on that edge.
REQ-021 IDLE with scan_start=1 and num_pts=0 SHALL go to FINISH, issuing no requests.
REQ-022 ISSUE SHALL assert calc_start for exactly one cycle, then go to WAIT_CALC.
REQ-023 Coordinates SHALL be held stable from the ISSUE cycle until calc_done is sampled:
- calc_x_i = ELEM_X0 + e*ELEM_PITCH
- calc_z_i = 0
- calc_x_f = latched x_focus
- calc_z_f = z_first + p*z_step
REQ-024 All coordinate arithmetic SHALL be mod 2^16 (wrap, no saturation).
REQ-025 WAIT_CALC on calc_done=1 SHALL capture calc_delay into dly_data, set dly_valid=1, and go to OUTPUT.
REQ-026 WAIT_CALC SHALL count cycles; if TIMEOUT cycles pass without calc_done, it SHALL set timeout_err=1, drop busy, go to FINISH, and emit no further outputs.
REQ-027 OUTPUT SHALL hold dly_valid, dly_data, dly_elem=e, dly_pt=p and dly_last stable until dly_ready=1.
REQ-028 On the handshake cycle the block SHALL clear dly_valid and go to ADVANCE.
REQ-029 ADVANCE SHALL step the counters:
- e<NUM_ELEM-1: increment e, go to ISSUE.
- else if p<num_pts-1: e=0, increment p, go to ISSUE.
- else: go to FINISH.
REQ-030 FINISH SHALL pulse scan_done for one cycle and return to IDLE.
REQ-031 busy SHALL be 1 in every state except IDLE and FINISH.
REQ-032 scan_start while not in IDLE SHALL be ignored.
REQ-033 calc_done outside WAIT_CALC SHALL be ignored.
REQ-034 Latency: calc_start SHALL go high the 2nd edge after scan_start is sampled, and again 2 cycles after each output handshake.
REQ-035 timeout_err SHALL clear only on reset or on the next accepted scan_start.

Reset
REQ-036 On reset the block SHALL go to state IDLE with e=0, p=0 and the timeout counter at 0.
REQ-037 On reset all outputs SHALL be 0: calc_start, calc_*, dly_valid, dly_data, dly_elem, dly_pt, dly_last, busy, scan_done, timeout_err.
REQ-038 Reset mid-scan SHALL abort the scan with no scan_done pulse; a scan_start after reset SHALL begin a fresh scan.

Verification
REQ-039 Basic scan:
- stimulus: NUM_ELEM=4, pitch 4, x_focus=6, z_first=8, z_step=2, num_pts=2; mock calc_done 5 cycles after calc_start with delay=10*e+p.
- response: calc_x_i sequence 0,4,8,12 twice; calc_z_f 8 then 10; dly_data 0,10,20,30,1,11,21,31; dly_last only on the 8th output; one scan_done pulse.
REQ-040 Backpressure:
- stimulus: dly_ready held 0 for 7 cycles on output 2.
- response: dly_valid/dly_data held stable throughout; no calc_start until 2 cycles after the handshake.
REQ-041 Timeout:
- stimulus: mock never returns calc_done.
- response: timeout_err=1 after 64 wait cycles; one scan_done pulse; zero dly_valid; next scan_start clears timeout_err.
REQ-042 Zero-length and busy rejection:
- stimulus: num_pts=0, then scan_start pulsed mid-scan.
- response: the zero-length scan gives scan_done with no calc_start; the mid-scan pulse has no effect on the count.
REQ-043 Wrap and reset:
- stimulus: z_first=16'hFFFE, z_step=3.
- response: 2nd calc_z_f=16'h0001.
- stimulus: reset asserted during WAIT_CALC.
- response: all outputs 0 next cycle; no scan_done.
